// File: rtl/ins_dec_pkg.sv
// Shared widths, opcodes, field positions and the decoded-word struct for the instruction decoder.
// Optional branch flag: INS_DEC_BRANCH_FLAG_EN adds jmp_en to the decoded word.
package ins_dec_pkg;

    localparam int INS_W     = 11;
    localparam int OPC_W     = 3;
    localparam int REG_SEL_W = 2;
    localparam int DATA_W    = 4;

    localparam logic [OPC_W-1:0] OPC_NOP    = 3'b011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 3'b100;

    // Bit positions within the instruction word
    localparam int OPC_LSB      = 8;
    localparam int SEL_DATA_BIT = 9;
    localparam int ALU_OP_BIT   = 8;
    localparam int SEL_A_LSB    = 2;
    localparam int SEL_B_LSB    = 0;
    localparam int SEL_W_LSB    = 4;
    localparam int IMM_LSB      = 0;
    localparam int JMP_LSB      = 4;

    typedef struct packed {
        logic                 sel_data;
        logic                 write_en;
        logic                 alu_op;
`ifdef INS_DEC_BRANCH_FLAG_EN
        logic                 jmp_en;
`endif
        logic [REG_SEL_W-1:0] sel_a;
        logic [REG_SEL_W-1:0] sel_b;
        logic [REG_SEL_W-1:0] sel_w;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    jmp;
    } dec_t;

    // Only NOP (011) and BRANCH (100) leave the register file untouched.
    function automatic logic calc_write_en(input logic [OPC_W-1:0] opc);
        return (opc[2] | ~opc[1] | ~opc[0]) & (~opc[2] | opc[1] | opc[0]);
    endfunction

endpackage

// File: rtl/ins_dec_if.sv
// Instruction-in / decode-out bundle between the fetch stage and the datapath consumers.
// jmp_en exists only when INS_DEC_BRANCH_FLAG_EN is defined.
interface ins_dec_if;
    import ins_dec_pkg::*;

    logic                 ins_valid;
    logic [INS_W-1:0]     INS;
    logic                 dec_valid;
    logic                 sel_data;
    logic                 write_en;
    logic                 alu_op;
    logic [REG_SEL_W-1:0] SEL_A;
    logic [REG_SEL_W-1:0] SEL_B;
    logic [REG_SEL_W-1:0] SEL_W;
    logic [DATA_W-1:0]    IMM;
    logic [DATA_W-1:0]    JMP;
`ifdef INS_DEC_BRANCH_FLAG_EN
    logic                 jmp_en;
`endif

    modport master (
        output ins_valid, INS,
        input  dec_valid, sel_data, write_en, alu_op, SEL_A, SEL_B, SEL_W, IMM, JMP
`ifdef INS_DEC_BRANCH_FLAG_EN
      , input  jmp_en
`endif
    );

    modport slave (
        input  ins_valid, INS,
        output dec_valid, sel_data, write_en, alu_op, SEL_A, SEL_B, SEL_W, IMM, JMP
`ifdef INS_DEC_BRANCH_FLAG_EN
      , output jmp_en
`endif
    );

endinterface

// File: rtl/ins_dec_comb.sv
// Combinational field slicer: instruction word to decoded struct, write_en from opcode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module ins_dec_comb
    import ins_dec_pkg::*;
(
    input  logic [INS_W-1:0] ins,
    output dec_t             dec
);

    logic [OPC_W-1:0] opc;

    assign opc = ins[OPC_LSB +: OPC_W];

    // Overlapping fields are sliced regardless of opcode; consumers pick what they need.
    always_comb begin
        dec          = '0;
        dec.sel_data = ins[SEL_DATA_BIT];
        dec.alu_op   = ins[ALU_OP_BIT];
        dec.write_en = calc_write_en(opc);
`ifdef INS_DEC_BRANCH_FLAG_EN
        dec.jmp_en   = (opc == OPC_BRANCH);
`endif
        dec.sel_a    = ins[SEL_A_LSB +: REG_SEL_W];
        dec.sel_b    = ins[SEL_B_LSB +: REG_SEL_W];
        dec.sel_w    = ins[SEL_W_LSB +: REG_SEL_W];
        dec.imm      = ins[IMM_LSB   +: DATA_W];
        dec.jmp      = ins[JMP_LSB   +: DATA_W];
    end

endmodule

// File: rtl/ins_dec_reg.sv
// Registered instruction decoder; INS_DEC_BRANCH_FLAG_EN adds the jmp_en output.
// Latency: 1 cycle, no combinational input-to-output path.
// Backpressure: none; one instruction accepted every cycle.
module ins_dec_reg
    import ins_dec_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    ins_dec_if.slave   bus
);

    dec_t dec_d;
    dec_t dec_q;
    logic dec_valid_q;

    ins_dec_comb u_comb (
        .ins (bus.INS),
        .dec (dec_d)
    );

    // Idle cycles kill the strobes explicitly so an undriven INS cannot leak into them;
    // the data fields hold their last decoded value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q       <= '0;
            dec_valid_q <= 1'b0;
        end else if (bus.ins_valid) begin
            dec_q       <= dec_d;
            dec_valid_q <= 1'b1;
        end else begin
            dec_valid_q    <= 1'b0;
            dec_q.write_en <= 1'b0;
`ifdef INS_DEC_BRANCH_FLAG_EN
            dec_q.jmp_en   <= 1'b0;
`endif
        end
    end

    assign bus.dec_valid = dec_valid_q;
    assign bus.sel_data  = dec_q.sel_data;
    assign bus.write_en  = dec_q.write_en;
    assign bus.alu_op    = dec_q.alu_op;
    assign bus.SEL_A     = dec_q.sel_a;
    assign bus.SEL_B     = dec_q.sel_b;
    assign bus.SEL_W     = dec_q.sel_w;
    assign bus.IMM       = dec_q.imm;
    assign bus.JMP       = dec_q.jmp;
`ifdef INS_DEC_BRANCH_FLAG_EN
    assign bus.jmp_en    = dec_q.jmp_en;
`endif

endmodule

// File: tb/tb_ins_dec_reg.sv
// Directed-vector bench for ins_dec_reg; observed outputs packed as
// {dec_valid, sel_data, write_en, alu_op, SEL_A, SEL_B, SEL_W, IMM, JMP}.
module tb_ins_dec_reg;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    ins_dec_if bus_if ();

    ins_dec_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {bus_if.dec_valid, bus_if.sel_data, bus_if.write_en, bus_if.alu_op,
                  bus_if.SEL_A, bus_if.SEL_B, bus_if.SEL_W, bus_if.IMM, bus_if.JMP};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.ins_valid = 1'b1;
        bus_if.INS = 11'h7FF;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs !== 18'h0) begin
                miscompares++;
                $display("FAIL reset_cyc%0d: got %b want %b", i, obs, 18'h0);
            end
`ifdef INS_DEC_BRANCH_FLAG_EN
            vectors++;
            if (bus_if.jmp_en !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_jmp_en: got %b want 0", bus_if.jmp_en);
            end
`endif
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (obs !== 18'b1111_11_11_11_1111_1111) begin
            miscompares++;
            $display("FAIL reset_release_7ff: got %b want %b", obs, 18'b1111_11_11_11_1111_1111);
        end
    endtask

    task automatic test_zero_ones();
        bus_if.ins_valid = 1'b1;
        bus_if.INS = 11'h000;
        tick();
        bus_if.INS = 11'h7FF;
        vectors++;
        if (obs !== 18'b1010_00_00_00_0000_0000) begin
            miscompares++;
            $display("FAIL dec_000: got %b want %b", obs, 18'b1010_00_00_00_0000_0000);
        end
        // No combinational path: an input change between edges must not move outputs.
        #2;
        vectors++;
        if (obs !== 18'b1010_00_00_00_0000_0000) begin
            miscompares++;
            $display("FAIL no_comb_path: got %b want %b", obs, 18'b1010_00_00_00_0000_0000);
        end
        tick();
        vectors++;
        if (obs !== 18'b1111_11_11_11_1111_1111) begin
            miscompares++;
            $display("FAIL dec_7ff: got %b want %b", obs, 18'b1111_11_11_11_1111_1111);
        end
    endtask

    task automatic test_alternating();
        bus_if.ins_valid = 1'b1;
        bus_if.INS = 11'b10101010101;
        tick();
        bus_if.INS = 11'b01010101010;
        vectors++;
        if (obs !== 18'b1011_01_01_01_0101_0101) begin
            miscompares++;
            $display("FAIL dec_555: got %b want %b", obs, 18'b1011_01_01_01_0101_0101);
        end
        tick();
        vectors++;
        if (obs !== 18'b1110_10_10_10_1010_1010) begin
            miscompares++;
            $display("FAIL dec_2aa: got %b want %b", obs, 18'b1110_10_10_10_1010_1010);
        end
    endtask

    task automatic test_branch_nop();
        bus_if.ins_valid = 1'b1;
        bus_if.INS = 11'b10000000000;
        tick();
        bus_if.INS = 11'b01100000000;
        vectors++;
        if (obs !== 18'b1000_00_00_00_0000_0000) begin
            miscompares++;
            $display("FAIL dec_branch: got %b want %b", obs, 18'b1000_00_00_00_0000_0000);
        end
`ifdef INS_DEC_BRANCH_FLAG_EN
        vectors++;
        if (bus_if.jmp_en !== 1'b1) begin
            miscompares++;
            $display("FAIL branch_jmp_en: got %b want 1", bus_if.jmp_en);
        end
`endif
        tick();
        vectors++;
        if (obs !== 18'b1101_00_00_00_0000_0000) begin
            miscompares++;
            $display("FAIL dec_nop: got %b want %b", obs, 18'b1101_00_00_00_0000_0000);
        end
`ifdef INS_DEC_BRANCH_FLAG_EN
        vectors++;
        if (bus_if.jmp_en !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_jmp_en: got %b want 0", bus_if.jmp_en);
        end
`endif
    endtask

    // Every opcode presented on consecutive cycles; write_en per opcode from a hand table.
    task automatic test_back_to_back();
        logic [7:0] we_tab;
        logic [2:0] opc;
        we_tab = 8'b1110_0111;
        bus_if.ins_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            opc = 3'(i);
            bus_if.INS = {opc, 8'h3C};
            tick();
            vectors++;
            if (bus_if.dec_valid !== 1'b1 || bus_if.write_en !== we_tab[i]) begin
                miscompares++;
                $display("FAIL b2b_opc%0d: got valid=%b we=%b want valid=1 we=%b",
                         i, bus_if.dec_valid, bus_if.write_en, we_tab[i]);
            end
`ifdef INS_DEC_BRANCH_FLAG_EN
            vectors++;
            if (bus_if.jmp_en !== (i == 4)) begin
                miscompares++;
                $display("FAIL b2b_jmp_en_opc%0d: got %b want %b", i, bus_if.jmp_en, (i == 4));
            end
`endif
        end
    endtask

    task automatic test_hold();
        bus_if.ins_valid = 1'b1;
        bus_if.INS = 11'h555;
        tick();
        bus_if.ins_valid = 1'b0;
        bus_if.INS = 11'h7FF;
        tick();
        vectors++;
        if (obs !== 18'b0001_01_01_01_0101_0101) begin
            miscompares++;
            $display("FAIL hold_idle: got %b want %b", obs, 18'b0001_01_01_01_0101_0101);
        end
        bus_if.INS = 'x;
        tick();
        vectors++;
        if (bus_if.dec_valid !== 1'b0 || bus_if.write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_x_ins: got valid=%b we=%b want 0 0", bus_if.dec_valid, bus_if.write_en);
        end
`ifdef INS_DEC_BRANCH_FLAG_EN
        vectors++;
        if (bus_if.jmp_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_x_jmp_en: got %b want 0", bus_if.jmp_en);
        end
`endif
    endtask

    task automatic test_midstream_reset();
        bus_if.ins_valid = 1'b1;
        bus_if.INS = 11'h7FF;
        tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (obs !== 18'h0) begin
            miscompares++;
            $display("FAIL midstream_reset: got %b want %b", obs, 18'h0);
        end
        rst_n = 1'b1;
        bus_if.ins_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus_if.ins_valid = 1'b0;
        bus_if.INS = '0;
        test_reset();
        test_zero_ones();
        test_alternating();
        test_branch_nop();
        test_back_to_back();
        test_hold();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
